// File: rtl/adc_pkg.sv
// adc_pkg: shared sample width, sequencer state encoding and default timing for the ADC blocks
package adc_pkg;
  localparam int ADC_W = 16;
  localparam int DEF_PERIOD = 400;
  localparam int DEF_TIMEOUT = 512;
  typedef enum logic [1:0] {IDLE, TRIGGER, WAIT_VALID} state_e;
endpackage

// File: rtl/adc_period_timer.sv
// adc_period_timer: counts 0..PERIOD-1 while EN, TICK high on the wrap cycle
module adc_period_timer import adc_pkg::*; #(
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic CLK,
  input  logic rst,
  input  logic EN,
  output logic TICK
);
  localparam int W = $clog2(PERIOD);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    TICK = EN && cnt_q == W'(PERIOD - 1);
    cnt_d = (!EN || TICK) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge CLK)
    cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/adc_sample_averager.sv
// adc_sample_averager: paces ADC conversions, averages 2^LOG2_AVG samples, valid/ready output with sticky errors
module adc_sample_averager import adc_pkg::*; #(
  parameter int LOG2_AVG = 2,
  parameter int PERIOD = DEF_PERIOD,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             EN,
  input  logic             CLR_ERR,
  output logic             CNV_START,
  input  logic             BUSY,
  input  logic             VALID,
  input  logic [ADC_W-1:0] RESULT,
  output logic [ADC_W-1:0] AVG_OUT,
  output logic             AVG_VALID,
  input  logic             AVG_READY,
  output logic             OVERRUN,
  output logic             TIMEOUT_ERR
);
  localparam int ACC_W = ADC_W + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic pend_q, pend_d, cnv_q, cnv_d, vld_q, vld_d, ovr_q, ovr_d, terr_q, terr_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
  logic [TO_W-1:0] to_q, to_d;
  logic [ADC_W-1:0] avg_q, avg_d;
  logic tick, take, pub, expired, ovr_set, terr_set;
  adc_period_timer #(.PERIOD(PERIOD)) u_timer (
    .CLK(CLK),
    .rst(rst),
    .EN(EN),
    .TICK(tick)
  );
  always_comb begin
    acc_nx = acc_q + ACC_W'(RESULT);
    cnt_nx = cnt_q + 1'b1;
    expired = to_q == TO_W'(TIMEOUT - 1);
    take = state_q == IDLE && pend_q && EN;
    // a wrap while a request is already pending is absorbed, never queued
    pend_d = EN && !take && (pend_q || tick);
    state_d = state_q;
    cnv_d = cnv_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    to_d = to_q + 1'b1;
    pub = 1'b0;
    terr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = TRIGGER;
          cnv_d = 1'b1;
          to_d = '0;
        end else if (!EN) begin
          acc_d = '0;
          cnt_d = '0;
        end
      end
      TRIGGER: begin
        if (BUSY) begin
          state_d = WAIT_VALID;
          cnv_d = 1'b0;
          to_d = '0;
        end else begin
          terr_set = expired;
        end
      end
      WAIT_VALID: begin
        if (VALID) begin
          state_d = IDLE;
          pub = cnt_nx == CNT_W'(1 << LOG2_AVG);
          acc_d = pub ? '0 : acc_nx;
          cnt_d = pub ? '0 : cnt_nx;
        end else begin
          terr_set = expired;
        end
      end
      default: state_d = IDLE;
    endcase
    if (terr_set) begin
      state_d = IDLE;
      cnv_d = 1'b0;
      acc_d = '0;
      cnt_d = '0;
    end
    ovr_set = pub && vld_q && !AVG_READY;
    avg_d = (pub && !ovr_set) ? acc_nx[ACC_W-1 -: ADC_W] : avg_q;
    vld_d = pub || (vld_q && !AVG_READY);
    ovr_d = ovr_set || (ovr_q && !CLR_ERR);
    terr_d = terr_set || (terr_q && !CLR_ERR);
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      cnv_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      avg_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      cnv_q <= cnv_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      avg_q <= avg_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
      terr_q <= terr_d;
    end
  end
  assign CNV_START = cnv_q;
  assign AVG_OUT = avg_q;
  assign AVG_VALID = vld_q;
  assign OVERRUN = ovr_q;
  assign TIMEOUT_ERR = terr_q;
endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: ADC behavioural model, mean scoreboard and directed timing/error checks
module tb_adc_sample_averager;
  localparam int P = 20, T = 512, CONV_LEN = 8, PB = 10;
  logic clk = 0, rst = 1, en = 0, en_b = 0, clr_err = 0;
  logic cnv_a, busy_a = 0, valid_a = 0, avg_valid_a, avg_ready_a, ovr_a, terr_a;
  logic rdy_main = 1, rdy_force = 0;
  logic [15:0] result_a = 0, avg_out_a, last_out = 0;
  logic cnv_b, busy_b = 0, valid_b = 0, avg_valid_b, ovr_b, terr_b;
  logic [15:0] result_b = 0, avg_out_b, exp_b = 0;
  int n_tests = 0, n_fail = 0, nout = 0, nval = 0, nb = 0, busy_dly = 1;
  bit adc_dead = 0, lat_en = 1, ready_on_last = 0;
  int grp[$];
  logic [15:0] exp_q[$], sample_q[$];
  assign avg_ready_a = rdy_main | rdy_force;
  always #5 clk = ~clk;
  adc_sample_averager #(.LOG2_AVG(2), .PERIOD(P), .TIMEOUT(T)) dut_a (
    .CLK(clk), .rst(rst), .EN(en), .CLR_ERR(clr_err), .CNV_START(cnv_a), .BUSY(busy_a),
    .VALID(valid_a), .RESULT(result_a), .AVG_OUT(avg_out_a), .AVG_VALID(avg_valid_a),
    .AVG_READY(avg_ready_a), .OVERRUN(ovr_a), .TIMEOUT_ERR(terr_a)
  );
  adc_sample_averager #(.LOG2_AVG(0), .PERIOD(PB), .TIMEOUT(T)) dut_b (
    .CLK(clk), .rst(rst), .EN(en_b), .CLR_ERR(clr_err), .CNV_START(cnv_b), .BUSY(busy_b),
    .VALID(valid_b), .RESULT(result_b), .AVG_OUT(avg_out_b), .AVG_VALID(avg_valid_b),
    .AVG_READY(1'b1), .OVERRUN(ovr_b), .TIMEOUT_ERR(terr_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  // ADC A: acknowledges a request after busy_dly cycles, returns a sample CONV_LEN cycles later
  initial begin
    logic [15:0] s;
    int sum;
    bit done, lat;
    forever begin
      @(negedge clk);
      if (cnv_a === 1'b1 && !adc_dead && !rst) begin
        for (int i = 0; i < busy_dly; i++) begin
          @(negedge clk);
          check("cnv_hold", cnv_a, 1);
        end
        busy_a = 1;
        @(negedge clk);
        check("cnv_fall", cnv_a, 0);
        repeat (CONV_LEN - 1) @(negedge clk);
        busy_a = 0;
        if (sample_q.size() != 0) s = sample_q.pop_front();
        else s = 16'($urandom);
        grp.push_back(int'(s));
        done = grp.size() == 4;
        lat = done && lat_en;
        if (lat) check("avg_pre", avg_valid_a, 0);
        if (done) begin
          sum = 0;
          foreach (grp[j]) sum += grp[j];
          exp_q.push_back(16'(sum >> 2));
          grp.delete();
          rdy_force = ready_on_last;
        end
        result_a = s;
        valid_a = 1;
        nval++;
        @(negedge clk);
        valid_a = 0;
        if (lat) begin
          #1;
          check("avg_lat", avg_valid_a, 1);
        end
      end
    end
  end
  always begin
    @(negedge clk);
    #1;
    if (avg_valid_a && avg_ready_a) begin
      if (exp_q.size() == 0) check("avg_extra", exp_q.size(), 1);
      else begin
        check("avg_out", avg_out_a, exp_q.pop_front());
        last_out = avg_out_a;
        nout++;
      end
    end
  end
  // ADC B: single-sample averaging, every conversion must be echoed
  initial begin
    forever begin
      @(negedge clk);
      if (cnv_b === 1'b1 && !rst) begin
        @(negedge clk);
        busy_b = 1;
        repeat (4) @(negedge clk);
        busy_b = 0;
        result_b = nb < 3 ? 16'h1234 : 16'($urandom);
        exp_b = result_b;
        valid_b = 1;
        @(negedge clk);
        valid_b = 0;
      end
    end
  end
  always begin
    @(negedge clk);
    #1;
    if (avg_valid_b) begin
      check("avg_b", avg_out_b, exp_b);
      nb++;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, n0;
    sample_q = '{16'd100, 16'd200, 16'd300, 16'd401, 16'hffff, 16'hffff, 16'hffff, 16'hffff};
    repeat (3) @(negedge clk);
    #1;
    check("rst_cnv", cnv_a, 0);
    check("rst_avg", avg_out_a, 0);
    check("rst_vld", avg_valid_a, 0);
    check("rst_ovr", ovr_a, 0);
    check("rst_terr", terr_a, 0);
    @(negedge clk);
    rst = 0;
    en = 1;
    en_b = 1;
    k = 0; while (nout < 2 && k < 2000) begin @(negedge clk); k++; end
    check("first_groups", nout, 2);
    check("avg_ffff", last_out, 16'hffff);
    busy_dly = 40;
    n0 = nval;
    k = 0; while (nval < n0 + 2 && k < 2000) begin @(negedge clk); k++; end
    check("busy40_done", nval >= n0 + 2, 1);
    busy_dly = 1;
    k = 0; while (exp_q.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    lat_en = 0;
    rdy_main = 0;
    k = 0; while (exp_q.size() < 2 && k < 2000) begin @(negedge clk); k++; end
    check("ovr_groups", exp_q.size(), 2);
    @(negedge clk);
    #1;
    check("ovr_vld", avg_valid_a, 1);
    check("ovr_hold", avg_out_a, exp_q[0]);
    check("ovr_flag", ovr_a, 1);
    void'(exp_q.pop_back());
    @(negedge clk);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    #1;
    check("ovr_clr", ovr_a, 0);
    ready_on_last = 1;
    k = 0; while (exp_q.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    check("swap_drain", exp_q.size(), 0);
    #1;
    check("ovr_stay0", ovr_a, 0);
    ready_on_last = 0;
    rdy_main = 1;
    lat_en = 1;
    k = 0; while (grp.size() != 1 && k < 2000) begin @(negedge clk); k++; end
    adc_dead = 1;
    k = 0; while (cnv_a !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    check("to_cnv", cnv_a, 1);
    repeat (T - 1) @(negedge clk);
    #1;
    check("to_cnv_held", cnv_a, 1);
    check("to_pre", terr_a, 0);
    @(negedge clk);
    #1;
    check("to_cnv_drop", cnv_a, 0);
    check("to_err", terr_a, 1);
    grp.delete();
    adc_dead = 0;
    @(negedge clk);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    #1;
    check("to_clr", terr_a, 0);
    n0 = nout;
    k = 0; while (nout < n0 + 1 && k < 2000) begin @(negedge clk); k++; end
    check("to_next_group", nout, n0 + 1);
    k = 0; while (grp.size() != 2 && k < 2000) begin @(negedge clk); k++; end
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_rst_cnv", cnv_a, 0);
    check("mid_rst_avg", avg_out_a, 0);
    check("mid_rst_vld", avg_valid_a, 0);
    check("mid_rst_ovr", ovr_a, 0);
    check("mid_rst_terr", terr_a, 0);
    @(negedge clk);
    grp.delete();
    exp_q.delete();
    sample_q = '{16'd8, 16'd8, 16'd8, 16'd8};
    n0 = nout;
    rst = 0;
    k = 0; while (nout < n0 + 1 && k < 2000) begin @(negedge clk); k++; end
    check("rst_avg8", last_out, 8);
    k = 0; while (!(grp.size() == 3 && busy_a) && k < 2000) begin @(negedge clk); k++; end
    n0 = nout;
    en = 0;
    k = 0; while (!valid_a && k < 200) begin @(negedge clk); k++; end
    check("en_inflight_valid", valid_a, 1);
    k = 0;
    repeat (3 * P) begin
      @(negedge clk);
      if (cnv_a) k++;
    end
    check("en_no_cnv", k, 0);
    check("en_inflight_out", nout, n0 + 1);
    grp.delete();
    en = 1;
    k = 0; while (cnv_a !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    check("en_restart", k, P + 1);
    repeat (800) begin
      @(negedge clk);
      rdy_main = $urandom_range(0, 3) != 0;
    end
    rdy_main = 1;
    k = 0; while (exp_q.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    check("final_drain", exp_q.size(), 0);
    check("b_seen", nb > 5, 1);
    check("b_err", {ovr_b, terr_b}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
